// File: rtl/countdown_sequencer_if.sv
// Control/status bundle between host logic and countdown_sequencer.
// The host drives load_val/start/pause/abort and observes the count, busy,
// done and the FSM state.
interface countdown_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output load_val, start, pause, abort,
    input  q, busy, done, state
  );

  modport slave (
    input  load_val, start, pause, abort,
    output q, busy, done, state
  );
endinterface

// File: rtl/countdown_sequencer.sv
// countdown_sequencer: sequences a synchronous down counter with optional
// prescaler. Start loads the count and runs, pause holds it, abort returns
// to IDLE, and done pulses for one cycle on the terminal count.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN for periodic mode, where
// the terminal tick reloads the last start value and stays in RUN.
module countdown_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  countdown_sequencer_if.slave  bus
);

  // Prescaler is at least one bit wide even when PRESCALE==1 (always 0 then).
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic             r_busy;
  logic             r_done;
  logic [PW-1:0]    r_presc;
  logic [WIDTH-1:0] r_reload;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_busy_next;
  logic             w_done_next;
  logic [PW-1:0]    w_presc_next;
  logic [WIDTH-1:0] w_reload_next;
  logic             w_tick;

  // A decrement happens only when the prescaler has reached its last phase.
  assign w_tick = (r_presc == PS_LAST);

  // Next-state and datapath: abort beats start, start beats pause, pause beats tick.
  always_comb begin
    w_state_next  = r_state;
    w_q_next      = r_q;
    w_done_next   = 1'b0;
    w_presc_next  = r_presc;
    w_reload_next = r_reload;

    if (bus.abort) begin
      w_state_next = ST_IDLE;
      w_q_next     = '0;
      w_presc_next = '0;
    end else if (bus.start) begin
      w_reload_next = bus.load_val;
      w_presc_next  = '0;
      if (bus.load_val == '0) begin
        // Nothing to count: complete immediately.
        w_state_next = ST_DONE;
        w_q_next     = '0;
        w_done_next  = 1'b1;
      end else begin
        w_state_next = ST_RUN;
        w_q_next     = bus.load_val;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_q_next = '0;
        end
        ST_RUN: begin
          if (bus.pause) begin
            // Entering PAUSED consumes this edge; prescaler holds its phase.
            w_state_next = ST_PAUSED;
          end else if (w_tick) begin
            w_presc_next = '0;
            if (r_q <= WIDTH'(1)) begin
              // Terminal tick; the <= also keeps q from ever wrapping below 0.
              w_done_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              w_q_next = r_reload;
`else
              w_q_next     = '0;
              w_state_next = ST_DONE;
`endif
            end else begin
              w_q_next = r_q - 1'b1;
            end
          end else begin
            w_presc_next = r_presc + 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!bus.pause) begin
            w_state_next = ST_RUN;
          end
        end
        ST_DONE: begin
          w_q_next = '0;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_q_next     = '0;
          w_presc_next = '0;
        end
      endcase
    end

    w_busy_next = (w_state_next == ST_RUN) || (w_state_next == ST_PAUSED);
  end

  // State, count, status and prescaler registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_q      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_presc  <= '0;
      r_reload <= '0;
    end else begin
      r_state  <= w_state_next;
      r_q      <= w_q_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_presc  <= w_presc_next;
      r_reload <= w_reload_next;
    end
  end

  assign bus.q     = r_q;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.state = r_state;

endmodule
